// File: rtl/freq_analysis.sv
// freq_analysis: finds the largest-magnitude bin of a 16-bin FFT frame.
// A frame is scanned one bin per cycle. A single pending frame can be
// buffered while a scan is in progress.
//
// Ports:
//   CLK             rising-edge clock
//   RST             asynchronous, active-high reset
//   fft_valid       one-cycle strobe; fft_d0..fft_d15 hold a frame
//   fft_d0..fft_d15 bin k = {real[31:16], imag[15:0]}, signed Q8.8
//   done            one-cycle pulse; freq holds a new result
//   freq            index of the largest-magnitude bin (lowest index on ties)
//   ovf             one-cycle pulse; the buffered frame was overwritten
module freq_analysis (
    input  logic        CLK,
    input  logic        RST,
    input  logic        fft_valid,
    input  logic [31:0] fft_d0,
    input  logic [31:0] fft_d1,
    input  logic [31:0] fft_d2,
    input  logic [31:0] fft_d3,
    input  logic [31:0] fft_d4,
    input  logic [31:0] fft_d5,
    input  logic [31:0] fft_d6,
    input  logic [31:0] fft_d7,
    input  logic [31:0] fft_d8,
    input  logic [31:0] fft_d9,
    input  logic [31:0] fft_d10,
    input  logic [31:0] fft_d11,
    input  logic [31:0] fft_d12,
    input  logic [31:0] fft_d13,
    input  logic [31:0] fft_d14,
    input  logic [31:0] fft_d15,
    output logic        done,
    output logic [3:0]  freq,
    output logic        ovf
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  best_q, best_d;
    logic [3:0]  freq_q, freq_d;
    logic [31:0] max_q, max_d;
    logic        pend_q, pend_d;
    logic        done_q, done_d;
    logic        ovf_q, ovf_d;
    logic [31:0] work_q [16];
    logic [31:0] work_d [16];
    logic [31:0] pbank_q [16];
    logic [31:0] pbank_d [16];
    logic [31:0] frame [16];

    logic [31:0]        cur;
    logic signed [31:0] re_ext, im_ext, re_sq, im_sq;
    logic [31:0]        mag;
    logic               take;

    always_comb begin
        frame = '{fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7,
                  fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15};
    end

    // Squares of 16-bit signed values are at most 2^30, so the unsigned
    // sum is at most 2^31 and cannot wrap in 32 bits.
    always_comb begin
        cur    = work_q[idx_q];
        re_ext = {{16{cur[31]}}, cur[31:16]};
        im_ext = {{16{cur[15]}}, cur[15:0]};
        re_sq  = re_ext * re_ext;
        im_sq  = im_ext * im_ext;
        mag    = $unsigned(re_sq) + $unsigned(im_sq);
        take   = (idx_q == 4'd0) || (mag > max_q);
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        best_d  = best_q;
        max_d   = max_q;
        freq_d  = freq_q;
        pend_d  = pend_q;
        done_d  = 1'b0;
        ovf_d   = 1'b0;
        work_d  = work_q;
        pbank_d = pbank_q;
        case (state_q)
            IDLE: begin
                if (fft_valid) begin
                    work_d  = frame;
                    idx_d   = 4'd0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (take) begin
                    max_d  = mag;
                    best_d = idx_q;
                end
                if (idx_q == 4'd15) begin
                    freq_d  = best_d;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
                if (fft_valid) begin
                    pbank_d = frame;
                    pend_d  = 1'b1;
                    ovf_d   = pend_q;
                end
            end
            DONE: begin
                idx_d = 4'd0;
                if (pend_q) begin
                    // Buffered frame moves to the working bank; a frame arriving
                    // on the same edge refills the buffer without an overflow.
                    work_d  = pbank_q;
                    state_d = SCAN;
                    if (fft_valid) begin
                        pbank_d = frame;
                    end else begin
                        pend_d = 1'b0;
                    end
                end else if (fft_valid) begin
                    work_d  = frame;
                    state_d = SCAN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            idx_q   <= '0;
            best_q  <= '0;
            max_q   <= '0;
            freq_q  <= '0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            best_q  <= best_d;
            max_q   <= max_d;
            freq_q  <= freq_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    // Bank contents need no reset; they are always written before use.
    always_ff @(posedge CLK) begin
        work_q  <= work_d;
        pbank_q <= pbank_d;
    end

    assign done = done_q;
    assign freq = freq_q;
    assign ovf  = ovf_q;
endmodule

// File: tb/tb_freq_analysis.sv
module tb_freq_analysis;
    typedef logic [31:0] frame_t [16];

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       fft_valid = 1'b0;
    frame_t     d;
    logic       done;
    logic [3:0] freq;
    logic       ovf;

    int vectors = 0;
    int miscompares = 0;
    int edge_n = 0;

    // reference model state
    bit active = 0;
    int done_at = -1;
    bit pend = 0;
    int pend_arg = 0;
    int cur_arg = 0;
    int exp_freq = 0;
    bit exp_done = 0;
    bit exp_ovf = 0;

    int done_e[$];
    int dfreq[$];
    int ovf_cnt = 0;

    freq_analysis dut (
        .CLK(CLK), .RST(RST), .fft_valid(fft_valid),
        .fft_d0(d[0]), .fft_d1(d[1]), .fft_d2(d[2]), .fft_d3(d[3]),
        .fft_d4(d[4]), .fft_d5(d[5]), .fft_d6(d[6]), .fft_d7(d[7]),
        .fft_d8(d[8]), .fft_d9(d[9]), .fft_d10(d[10]), .fft_d11(d[11]),
        .fft_d12(d[12]), .fft_d13(d[13]), .fft_d14(d[14]), .fft_d15(d[15]),
        .done(done), .freq(freq), .ovf(ovf)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mk(input int re, input int im);
        logic [15:0] r, i;
        r = 16'(re);
        i = 16'(im);
        return {r, i};
    endfunction

    function automatic int argmax(input frame_t f);
        longint best = -1;
        int bi = 0;
        for (int k = 0; k < 16; k++) begin
            longint re = longint'($signed(f[k][31:16]));
            longint im = longint'($signed(f[k][15:0]));
            longint m = re * re + im * im;
            if (m > best) begin
                best = m;
                bi = k;
            end
        end
        return bi;
    endfunction

    task automatic chk(input string name, input int got, input int expv);
        vectors++;
        if (got != expv) begin
            miscompares++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_n, got, expv);
        end
    endtask

    task automatic model_reset();
        active = 0; pend = 0; exp_freq = 0; exp_done = 0; exp_ovf = 0; done_at = -1;
    endtask

    // A frame that starts processing on edge n produces its result on edge n+16;
    // the following edge decides what, if anything, starts next.
    task automatic model_edge(input bit v, input int a);
        exp_done = 0;
        exp_ovf = 0;
        if (active && edge_n <= done_at) begin
            if (edge_n == done_at) begin
                exp_done = 1;
                exp_freq = cur_arg;
            end
            if (v) begin
                if (pend) exp_ovf = 1;
                pend = 1;
                pend_arg = a;
            end
        end else if (active && edge_n == done_at + 1) begin
            if (pend) begin
                cur_arg = pend_arg;
                done_at = edge_n + 16;
                if (v) pend_arg = a; else pend = 0;
            end else if (v) begin
                cur_arg = a;
                done_at = edge_n + 16;
            end else begin
                active = 0;
            end
        end else if (v) begin
            active = 1;
            cur_arg = a;
            done_at = edge_n + 16;
        end
    endtask

    always @(posedge CLK) begin
        edge_n++;
        if (RST) model_reset();
        else model_edge(fft_valid, argmax(d));
        #1;
        chk("done", int'(done), int'(exp_done));
        chk("freq", int'(freq), exp_freq);
        chk("ovf", int'(ovf), int'(exp_ovf));
        if (done === 1'b1) begin
            done_e.push_back(edge_n);
            dfreq.push_back(int'(freq));
        end
        if (ovf === 1'b1) ovf_cnt++;
    end

    function automatic int q_at(input int q[$], input int i);
        return (q.size() > i) ? q[i] : -1;
    endfunction

    task automatic clear_rec();
        done_e.delete();
        dfreq.delete();
        ovf_cnt = 0;
    endtask

    task automatic zero_frame();
        for (int k = 0; k < 16; k++) d[k] = '0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge CLK);
            fft_valid = 1'b0;
        end
    endtask

    task automatic send(output int e);
        @(negedge CLK);
        fft_valid = 1'b1;
        e = edge_n + 1;
        @(negedge CLK);
        fft_valid = 1'b0;
    endtask

    initial begin
        frame_t f;
        int e0, e1, e2;

        zero_frame();
        // literal pins on the reference model
        for (int k = 0; k < 16; k++) f[k] = '0;
        f[3] = mk(-200, 0); f[9] = mk(100, 150);
        chk("model_req030a", argmax(f), 3);
        for (int k = 0; k < 16; k++) f[k] = '0;
        chk("model_zero", argmax(f), 0);
        f[14] = mk(-32768, -32768); f[1] = mk(32767, 32767);
        chk("model_bin14", argmax(f), 14);
        for (int k = 0; k < 16; k++) f[k] = '0;
        f[2] = mk(0, 50); f[11] = mk(0, 50);
        chk("model_tie", argmax(f), 2);

        // reset state
        repeat (3) @(negedge CLK);
        chk("rst_done", int'(done), 0);
        chk("rst_freq", int'(freq), 0);
        chk("rst_ovf", int'(ovf), 0);
        RST = 1'b0;
        idle(2);

        // single frame, bin5
        clear_rec();
        zero_frame(); d[5] = mk(100, 0);
        send(e0); idle(20);
        chk("lat16", q_at(done_e, 0) - e0, 16);
        chk("single_freq", q_at(dfreq, 0), 5);
        chk("single_ovf", ovf_cnt, 0);

        // magnitude comparisons, all-zero frame, extreme bin
        clear_rec();
        zero_frame(); d[3] = mk(-200, 0); d[9] = mk(100, 150);
        send(e0); idle(20);
        zero_frame();
        send(e0); idle(20);
        zero_frame(); d[14] = mk(-32768, -32768); d[1] = mk(32767, 32767); d[6] = mk(-32768, 32767);
        send(e0); idle(20);
        zero_frame(); d[2] = mk(0, 50); d[11] = mk(0, 50);
        send(e0); idle(20);
        chk("mag_freq", q_at(dfreq, 0), 3);
        chk("zero_freq", q_at(dfreq, 1), 0);
        chk("max_freq", q_at(dfreq, 2), 14);
        chk("tie_freq", q_at(dfreq, 3), 2);

        // two frames 4 cycles apart
        clear_rec();
        zero_frame(); d[7] = mk(10, 0);
        send(e0); idle(2);
        zero_frame(); d[12] = mk(0, 20);
        send(e1); idle(40);
        chk("b2b_gap", q_at(done_e, 1) - q_at(done_e, 0), 17);
        chk("b2b_f0", q_at(dfreq, 0), 7);
        chk("b2b_f1", q_at(dfreq, 1), 12);
        chk("b2b_ovf", ovf_cnt, 0);

        // three frames within one scan: middle one dropped
        clear_rec();
        zero_frame(); d[1] = mk(30, 0);
        send(e0);
        zero_frame(); d[2] = mk(30, 0);
        send(e1); idle(1);
        zero_frame(); d[3] = mk(30, 0);
        send(e2); idle(40);
        chk("abc_ovf", ovf_cnt, 1);
        chk("abc_n", done_e.size(), 2);
        chk("abc_f0", q_at(dfreq, 0), 1);
        chk("abc_f1", q_at(dfreq, 1), 3);

        // reset at idx=8
        clear_rec();
        zero_frame(); d[4] = mk(90, 0);
        send(e0); idle(8);
        RST = 1'b1;
        #1;
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_freq", int'(freq), 0);
        idle(2);
        RST = 1'b0;
        idle(20);
        chk("post_rst_ndone", done_e.size(), 0);
        chk("post_rst_freq", int'(freq), 0);
        zero_frame(); d[9] = mk(-70, 5);
        send(e0); idle(20);
        chk("post_rst_lat", q_at(done_e, 0) - e0, 16);
        chk("post_rst_f", q_at(dfreq, 0), 9);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            int mode;
            @(negedge CLK);
            if (RST) RST = 1'b0;
            else if ($urandom_range(0, 299) == 0) RST = 1'b1;
            mode = $urandom_range(0, 2);
            for (int k = 0; k < 16; k++) begin
                if (mode == 0) d[k] = $urandom;
                else if (mode == 1) d[k] = mk($urandom_range(0, 600) - 300, $urandom_range(0, 600) - 300);
                else d[k] = mk(10 * $urandom_range(0, 3), 10 * $urandom_range(0, 3));
            end
            fft_valid = ($urandom_range(0, 5) == 0);
        end
        idle(40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
